// File: rtl/synth_pkg.sv
// Shared types and sizes for the voice allocator.
// Contents: voice geometry, allocator FSM states, voice and latched-event records.
package synth_pkg;

  localparam int unsigned NUM_VOICES = 4;
  localparam int unsigned NOTE_W     = 7;
  localparam int unsigned VEL_W      = 7;
  localparam int unsigned AGE_W      = 8;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned STEAL_W    = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ALLOC = 1'b1
  } alloc_state_t;

  typedef struct packed {
    logic              active;
    logic [NOTE_W-1:0] note;
    logic [VEL_W-1:0]  vel;
    logic [AGE_W-1:0]  age;
  } voice_t;

  // Note event captured at the handshake, consumed in ALLOC.
  typedef struct packed {
    logic              on;
    logic [NOTE_W-1:0] note;
    logic [VEL_W-1:0]  vel;
  } note_ev_t;

endpackage

// File: rtl/voice_select.sv
// Combinational priority finder over the voice slots.
// Ports:
//   active     - per-voice gate
//   notes      - per-voice note number
//   ages       - per-voice age
//   ev_note    - note being looked up
//   match_hit/match_idx - lowest active voice playing ev_note
//   free_hit/free_idx   - lowest inactive voice
//   oldest_idx          - voice with maximum age, ties to lowest index
module voice_select
  import synth_pkg::*;
(
  input  logic [NUM_VOICES-1:0]             active,
  input  logic [NUM_VOICES-1:0][NOTE_W-1:0] notes,
  input  logic [NUM_VOICES-1:0][AGE_W-1:0]  ages,
  input  logic [NOTE_W-1:0]                 ev_note,
  output logic                              match_hit,
  output logic [IDX_W-1:0]                  match_idx,
  output logic                              free_hit,
  output logic [IDX_W-1:0]                  free_idx,
  output logic [IDX_W-1:0]                  oldest_idx
);

  logic [AGE_W-1:0] best_age;

  // Descending scan so the lowest index wins for match/free.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (active[i] && (notes[i] == ev_note)) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (!active[i]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // Ascending scan with strict compare keeps the lowest index on ties.
  always_comb begin
    best_age   = ages[0];
    oldest_idx = '0;
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (ages[i] > best_age) begin
        best_age   = ages[i];
        oldest_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Assigns MIDI note events to the synthesis voices: retrigger on same note,
// else lowest free voice, else steal the oldest.
// Ports:
//   clk, reset_n         - clock, async active-low reset
//   ev_valid/ev_ready    - event handshake from the MIDI decoder (ev_ready combinational)
//   ev_on/ev_note/ev_vel - event payload
//   all_notes_off        - level; releases every active voice while idle
//   voice_active         - per-voice gate
//   voice_note/voice_vel - packed per-voice note and velocity
//   voice_trig/voice_rel - one-cycle start / release pulses
//   steal_count          - wrapping count of voice steals
module voice_allocator
  import synth_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_on,
  input  logic [NOTE_W-1:0]            ev_note,
  input  logic [VEL_W-1:0]             ev_vel,
  input  logic                         all_notes_off,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES*VEL_W-1:0]  voice_vel,
  output logic [NUM_VOICES-1:0]        voice_trig,
  output logic [NUM_VOICES-1:0]        voice_rel,
  output logic [STEAL_W-1:0]           steal_count
);

  alloc_state_t                state, state_next;
  voice_t [NUM_VOICES-1:0]     voices, voices_next;
  note_ev_t                    ev_q, ev_next;
  logic [NUM_VOICES-1:0]       trig_q, trig_next;
  logic [NUM_VOICES-1:0]       rel_q, rel_next;
  logic [STEAL_W-1:0]          steal_q, steal_next;

  logic [NUM_VOICES-1:0]             sel_active;
  logic [NUM_VOICES-1:0][NOTE_W-1:0] sel_notes;
  logic [NUM_VOICES-1:0][AGE_W-1:0]  sel_ages;
  logic                              match_hit, free_hit;
  logic [IDX_W-1:0]                  match_idx, free_idx, oldest_idx;
  logic [IDX_W-1:0]                  tgt;

  // Output and selector views of the voice registers.
  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_view
    assign sel_active[g]                      = voices[g].active;
    assign sel_notes[g]                       = voices[g].note;
    assign sel_ages[g]                        = voices[g].age;
    assign voice_active[g]                    = voices[g].active;
    assign voice_note[g*NOTE_W +: NOTE_W]     = voices[g].note;
    assign voice_vel[g*VEL_W +: VEL_W]        = voices[g].vel;
  end

  assign voice_trig  = trig_q;
  assign voice_rel   = rel_q;
  assign steal_count = steal_q;
  assign ev_ready    = (state == IDLE) && !all_notes_off;

  voice_select u_select (
    .active     (sel_active),
    .notes      (sel_notes),
    .ages       (sel_ages),
    .ev_note    (ev_q.note),
    .match_hit  (match_hit),
    .match_idx  (match_idx),
    .free_hit   (free_hit),
    .free_idx   (free_idx),
    .oldest_idx (oldest_idx)
  );

  // State and voice register file.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      voices  <= '0;
      ev_q    <= '0;
      trig_q  <= '0;
      rel_q   <= '0;
      steal_q <= '0;
    end else begin
      state   <= state_next;
      voices  <= voices_next;
      ev_q    <= ev_next;
      trig_q  <= trig_next;
      rel_q   <= rel_next;
      steal_q <= steal_next;
    end
  end

  // Next-state, voice update and pulse generation.
  always_comb begin
    state_next  = state;
    voices_next = voices;
    ev_next     = ev_q;
    trig_next   = '0;
    rel_next    = '0;
    steal_next  = steal_q;
    tgt         = '0;

    case (state)
      IDLE: begin
        if (all_notes_off) begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (voices[i].active) begin
              voices_next[i].active = 1'b0;
              voices_next[i].age    = '0;
              rel_next[i]           = 1'b1;
            end
          end
        end else if (ev_valid) begin
          ev_next.on   = ev_on;
          ev_next.note = ev_note;
          ev_next.vel  = ev_vel;
          state_next   = ALLOC;
        end
      end

      ALLOC: begin
        state_next = IDLE;
        // Zero velocity note-on is a note-off.
        if (ev_q.on && (ev_q.vel != '0)) begin
          if (match_hit) begin
            tgt = match_idx;
          end else if (free_hit) begin
            tgt = free_idx;
          end else begin
            tgt        = oldest_idx;
            steal_next = steal_q + STEAL_W'(1);
          end
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (IDX_W'(i) == tgt) begin
              voices_next[i].active = 1'b1;
              voices_next[i].note   = ev_q.note;
              voices_next[i].vel    = ev_q.vel;
              voices_next[i].age    = '0;
              trig_next[i]          = 1'b1;
            end else if (voices[i].active && (voices[i].age != {AGE_W{1'b1}})) begin
              voices_next[i].age = voices[i].age + AGE_W'(1);
            end
          end
        end else begin
          // Note and velocity stay put for the envelope release tail.
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (voices[i].active && (voices[i].note == ev_q.note)) begin
              voices_next[i].active = 1'b0;
              voices_next[i].age    = '0;
              rel_next[i]           = 1'b1;
            end
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: event table with a scoreboard
// queue, plus hand sequences for all_notes_off and reset corners.
module tb_voice_allocator;
  import synth_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ev_valid, ev_ready, ev_on, all_notes_off;
  logic [6:0]  ev_note, ev_vel;
  logic [3:0]  voice_active, voice_trig, voice_rel;
  logic [27:0] voice_note, voice_vel;
  logic [7:0]  steal_count;

  voice_allocator dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_on         (ev_on),
    .ev_note       (ev_note),
    .ev_vel        (ev_vel),
    .all_notes_off (all_notes_off),
    .voice_active  (voice_active),
    .voice_note    (voice_note),
    .voice_vel     (voice_vel),
    .voice_trig    (voice_trig),
    .voice_rel     (voice_rel),
    .steal_count   (steal_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        on;
    logic [6:0]  note;
    logic [6:0]  vel;
    logic [3:0]  act;
    logic [3:0]  trig;
    logic [3:0]  rel;
    logic [27:0] notes;
    logic [27:0] vels;
    logic [7:0]  steals;
  } vec_t;

  typedef struct {
    logic [3:0]  act;
    logic [3:0]  trig;
    logic [3:0]  rel;
    logic [27:0] notes;
    logic [27:0] vels;
    logic [7:0]  steals;
  } exp_t;

  vec_t tbl [11];
  exp_t sb [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [27:0] p4(input int a, input int b, input int c, input int d);
    return {7'(d), 7'(c), 7'(b), 7'(a)};
  endfunction

  function automatic vec_t mk(input int on, input int note, input int vel,
                              input logic [3:0] act, input logic [3:0] trig,
                              input logic [3:0] rel, input logic [27:0] notes,
                              input logic [27:0] vels, input int steals);
    vec_t v;
    v.on = 1'(on); v.note = 7'(note); v.vel = 7'(vel);
    v.act = act; v.trig = trig; v.rel = rel;
    v.notes = notes; v.vels = vels; v.steals = 8'(steals);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Handshake one event: push expectation at drive, pop when outputs update.
  task automatic send(input vec_t v, input int idx);
    exp_t e;
    e.act = v.act; e.trig = v.trig; e.rel = v.rel;
    e.notes = v.notes; e.vels = v.vels; e.steals = v.steals;
    ev_valid = 1'b1; ev_on = v.on; ev_note = v.note; ev_vel = v.vel;
    sb.push_back(e);
    chk($sformatf("ready_idle[%0d]", idx), 64'(ev_ready), 64'd1);
    @(posedge clk);
    #1 ev_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("ready_alloc[%0d]", idx), 64'(ev_ready), 64'd0);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk($sformatf("sb_empty[%0d]", idx), 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("active[%0d]", idx), 64'(voice_active), 64'(e.act));
      chk($sformatf("trig[%0d]", idx),   64'(voice_trig),   64'(e.trig));
      chk($sformatf("rel[%0d]", idx),    64'(voice_rel),    64'(e.rel));
      chk($sformatf("notes[%0d]", idx),  64'(voice_note),   64'(e.notes));
      chk($sformatf("vels[%0d]", idx),   64'(voice_vel),    64'(e.vels));
      chk($sformatf("steals[%0d]", idx), 64'(steal_count),  64'(e.steals));
    end
  endtask

  initial begin
    tbl[0]  = mk(1, 60, 100, 4'b0001, 4'b0001, 4'b0000, p4(60, 0, 0, 0),   p4(100, 0, 0, 0),   0);
    tbl[1]  = mk(1, 64, 90,  4'b0011, 4'b0010, 4'b0000, p4(60, 64, 0, 0),  p4(100, 90, 0, 0),  0);
    tbl[2]  = mk(1, 67, 80,  4'b0111, 4'b0100, 4'b0000, p4(60, 64, 67, 0), p4(100, 90, 80, 0), 0);
    tbl[3]  = mk(1, 72, 70,  4'b1111, 4'b1000, 4'b0000, p4(60, 64, 67, 72), p4(100, 90, 80, 70), 0);
    tbl[4]  = mk(1, 76, 50,  4'b1111, 4'b0001, 4'b0000, p4(76, 64, 67, 72), p4(50, 90, 80, 70),  1);
    tbl[5]  = mk(1, 64, 127, 4'b1111, 4'b0010, 4'b0000, p4(76, 64, 67, 72), p4(50, 127, 80, 70), 1);
    tbl[6]  = mk(0, 67, 64,  4'b1011, 4'b0000, 4'b0100, p4(76, 64, 67, 72), p4(50, 127, 80, 70), 1);
    tbl[7]  = mk(1, 67, 0,   4'b1011, 4'b0000, 4'b0000, p4(76, 64, 67, 72), p4(50, 127, 80, 70), 1);
    tbl[8]  = mk(1, 55, 60,  4'b1111, 4'b0100, 4'b0000, p4(76, 64, 55, 72), p4(50, 127, 60, 70), 1);
    tbl[9]  = mk(1, 80, 40,  4'b1111, 4'b1000, 4'b0000, p4(76, 64, 55, 80), p4(50, 127, 60, 40), 2);
    tbl[10] = mk(0, 64, 0,   4'b1101, 4'b0000, 4'b0010, p4(76, 64, 55, 80), p4(50, 127, 60, 40), 2);

    reset_n = 1'b0; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0; ev_vel = '0;
    all_notes_off = 1'b0;
    repeat (2) @(negedge clk);
    chk("ready_in_reset", 64'(ev_ready), 64'd1);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_active", 64'(voice_active), 64'd0);
    chk("rst_notes",  64'(voice_note),   64'd0);
    chk("rst_vels",   64'(voice_vel),    64'd0);
    chk("rst_pulses", 64'({voice_trig, voice_rel}), 64'd0);
    chk("rst_steals", 64'(steal_count),  64'd0);
    chk("rst_ready",  64'(ev_ready),     64'd1);

    for (int i = 0; i < 11; i++) send(tbl[i], i);

    @(negedge clk);
    chk("pulse_clear", 64'({voice_trig, voice_rel}), 64'd0);

    // all_notes_off with voices 0, 2, 3 active; held for two idle edges.
    all_notes_off = 1'b1;
    #1 chk("anf_ready", 64'(ev_ready), 64'd0);
    @(negedge clk);
    chk("anf_active", 64'(voice_active), 64'd0);
    chk("anf_rel",    64'(voice_rel),    64'b1101);
    chk("anf_trig",   64'(voice_trig),   64'd0);
    @(negedge clk);
    chk("anf_rel_once",  64'(voice_rel), 64'd0);
    chk("anf_ready_held", 64'(ev_ready), 64'd0);
    all_notes_off = 1'b0;
    #1 chk("anf_ready_drop", 64'(ev_ready), 64'd1);
    chk("anf_notes_kept", 64'(voice_note), 64'(p4(76, 64, 55, 80)));
    chk("anf_steals_kept", 64'(steal_count), 64'd2);

    // all_notes_off raised during ALLOC: event lands first, then released.
    @(negedge clk);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd30; ev_vel = 7'd33;
    @(posedge clk);
    #1 ev_valid = 1'b0; all_notes_off = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("anf_alloc_active", 64'(voice_active), 64'b0001);
    chk("anf_alloc_trig",   64'(voice_trig),   64'b0001);
    chk("anf_alloc_note0",  64'(voice_note[6:0]), 64'd30);
    @(negedge clk);
    chk("anf_alloc_rel",    64'(voice_rel),    64'b0001);
    chk("anf_alloc_off",    64'(voice_active), 64'd0);
    all_notes_off = 1'b0;

    // Reset dropped during ALLOC discards the latched event.
    @(negedge clk);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd10; ev_vel = 7'd10;
    @(posedge clk);
    #1 ev_valid = 1'b0; reset_n = 1'b0;
    #1;
    chk("rstA_active", 64'(voice_active), 64'd0);
    chk("rstA_notes",  64'(voice_note),   64'd0);
    chk("rstA_steals", 64'(steal_count),  64'd0);
    chk("rstA_ready",  64'(ev_ready),     64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstA_lost_active", 64'(voice_active), 64'd0);
    chk("rstA_lost_pulses", 64'({voice_trig, voice_rel}), 64'd0);
    chk("rstA_lost_notes",  64'(voice_note), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Assigns incoming MIDI note events to the 4 synthesis voices that feed the 4-input mixer.
- Acts as the arbiter that shares the fixed voice/mixer channels between an unbounded stream of note requests.
- Policies: retrigger on same note, else lowest free voice, else steal oldest.
- Sits between the MIDI message decoder (upstream, valid/ready) and the per-voice oscillator/envelope blocks (downstream, level + pulse signals).

Parameters:
- NUM_VOICES, 4, number of voice slots; must equal mixer input count.
- NOTE_W, 7, MIDI note number width.
- VEL_W, 7, MIDI velocity width.
- AGE_W, 8, per-voice age counter width; saturating.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ev_valid  in  1  event valid from MIDI decoder
- ev_ready  out  1  allocator can accept an event this cycle
- ev_on  in  1  1 = note-on, 0 = note-off
- ev_note  in  NOTE_W  note number
- ev_vel  in  VEL_W  velocity
- all_notes_off  in  1  level; releases every voice
- voice_active  out  NUM_VOICES  per-voice gate
- voice_note  out  NUM_VOICES*NOTE_W  packed; voice i at [i*NOTE_W +: NOTE_W]
- voice_vel  out  NUM_VOICES*VEL_W  packed; same layout
- voice_trig  out  NUM_VOICES  one-cycle pulse when a voice (re)starts
- voice_rel  out  NUM_VOICES  one-cycle pulse when a voice is released
- steal_count  out  8  number of voice steals; wraps at 255

Behaviour:
- Reset (async, reset_n low):
  - State IDLE; all outputs and internal registers 0.
  - Ages 0; any latched event discarded.
  - ev_ready is combinational, ev_ready = (state==IDLE) && !all_notes_off, so it may read 1 while reset_n is low.
- Handshake:
  - Transfer occurs on the rising edge where ev_valid && ev_ready.
  - Event fields are latched and the FSM moves IDLE -> ALLOC.
  - ev_ready is low in ALLOC. Throughput is 1 event per 2 cycles.
- ALLOC (1 cycle):
  - On the following edge, voice registers update, pulses assert for exactly that one cycle, and the FSM returns to IDLE.
  - Latency: outputs change 2 edges after the event is presented with ev_ready high.
- Note-on with ev_vel != 0, target selected in this priority:
  1. Lowest-index active voice with voice_note == ev_note. Retrigger: vel updated, age cleared, trig pulse.
  2. Else lowest-index inactive voice.
  3. Else steal the voice with maximum age (tie -> lowest index); steal_count += 1.
  - Target: active=1, note/vel loaded, age=0, voice_trig[target]=1.
  - Every other active voice: age += 1, saturating at 2^AGE_W-1.
  - voice_rel is never asserted on a steal.
- Note-on with ev_vel == 0 is treated exactly as note-off.
- Note-off:
  - Every active voice with a matching note is set active=0 and pulses voice_rel.
  - note/vel are retained for the envelope release tail.
  - No match: no output change. Ages unchanged.
- all_notes_off:
  - Sampled only in IDLE and takes priority over ev_valid, which is blocked by ev_ready=0.
  - On each IDLE edge while high: every active voice -> inactive with voice_rel pulse. Already-inactive voices do not pulse.
  - Held high: the pulse occurs once, since voices are then inactive.
  - If it asserts during ALLOC, the pending event completes first.
- Inactive voices keep age 0.
- steal_count is not cleared by all_notes_off.

Decomposition:
- Package synth_pkg holds:
  - NUM_VOICES, NOTE_W, VEL_W, AGE_W
  - state enum alloc_state_t {IDLE, ALLOC}
  - struct voice_t {active, note, vel, age}
- Sub-module voice_select:
  - Purely combinational priority finder.
  - Inputs: voice array, ev_note.
  - Outputs: match_hit/match_idx, free_hit/free_idx, oldest_idx.
  - Instantiated once in voice_allocator.

Test Plan:
- Reset release, ev_valid=0 -> all voice outputs 0, ev_ready=1, steal_count=0.
- Note-on 60/100, 64/90, 67/80, 72/70 in sequence -> voices 0..3 active with those notes; one trig pulse per voice; ev_ready low in each ALLOC cycle.
- From full state, note-on 76/50 -> voice 0 (age 3, oldest) loaded with 76; trig[0] pulse; no rel pulse; steal_count=1.
- Note-on 64/127 while 64 active in voice 1 -> voice 1 vel=127; trig[1]; no new voice used; ages of others +1.
- Note-off 67, then note-on 67 vel 0 -> first releases voice 2 (rel[2] pulse, note stays 67); second produces no change. Then note-on 55 -> lands in voice 2.
- all_notes_off asserted in IDLE with 3 active voices -> rel pulses on those 3 only, ev_ready=0 while high. Separately, drop reset_n during ALLOC -> all outputs 0 immediately and the latched event is lost.
